mem_fill_verify: RTL and testbench

//  Parametrised memory initialiser: on start, writes a pattern over an address range
//  [base_addr..last_addr] of a synchronous single-port RAM, one word per cycle.

---
 rtl/mem_fill_verify.sv | 162 ++++++++++++++++
 tb/tb_mem_fill_verify.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_verify.sv
// mem_fill_verify: fills an address range of a synchronous single-port RAM with a
// ramp or constant pattern, one word per cycle, then optionally reads the range
// back through a READ_LAT-deep expectation pipeline and records the first mismatch.
// Handshake: start is a level request sampled only in IDLE; the run ends in DONE,
// which is held while start stays high and left one cycle after start drops.
module mem_fill_verify #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] q,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(READ_LAT - 1);

    state_t            state;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] last_r;
    logic [DATA_W-1:0] fill_r;
    logic [2:0]        drain_cnt;

    // Expected word and address ride alongside the RAM read latency
    logic [READ_LAT-1:0] pipe_v;
    logic [DATA_W-1:0]   pipe_d [READ_LAT];
    logic [ADDR_W-1:0]   pipe_a [READ_LAT];
    logic                mismatch;

    // Ramp data is the address zero-extended or truncated to DATA_W bits
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic              const_mode,
                                                  input logic [DATA_W-1:0] f);
        logic [ADDR_W+DATA_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, a};
        return const_mode ? f : wide[DATA_W-1:0];
    endfunction

    // The oldest pipeline slot lines up with q from the RAM
    assign mismatch  = pipe_v[READ_LAT-1] && (q != pipe_d[READ_LAT-1]);
    assign dbg_state = state;

    // Fill/verify sequencer, expectation pipeline and sticky error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_r    <= '0;
            base_r    <= '0;
            last_r    <= '0;
            fill_r    <= '0;
            drain_cnt <= '0;
            write     <= 1'b0;
            address   <= '0;
            data      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= '0;
            pipe_v    <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_d[i] <= '0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= (state == S_VERIFY);
            pipe_d[0] <= pattern(address, mode_r[0], fill_r);
            pipe_a[0] <= address;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            // Only the first mismatch of a run is recorded
            if (mismatch && !error) begin
                error    <= 1'b1;
                err_addr <= pipe_a[READ_LAT-1];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        base_r   <= base_addr;
                        last_r   <= last_addr;
                        fill_r   <= fill_value;
                        error    <= 1'b0;
                        err_addr <= '0;
                        write    <= 1'b1;
                        address  <= base_addr;
                        data     <= pattern(base_addr, mode[0], fill_value);
                        busy     <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (address == last_r) begin
                        write <= 1'b0;
                        if (mode_r[1]) begin
                            address <= base_r;
                            state   <= S_VERIFY;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        address <= address + 1'b1;
                        data    <= pattern(ADDR_W'(address + 1'b1), mode_r[0], fill_r);
                    end
                end
                S_VERIFY: begin
                    if (address == last_r) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        address <= address + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_verify.sv
// Directed bench for mem_fill_verify: two instances (READ_LAT=1 and READ_LAT=3)
// share the stimulus, each with its own RAM model that can force addresses to 00.
// Done timing is reported as the edge number, counted from the start edge E,
// at which done is first sampled high.
module tb_mem_fill_verify;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] base_addr, last_addr, fill_value;

    logic       write0, busy0, done0, error0;
    logic [7:0] address0, data0, err_addr0, q0;
    logic [2:0] dbg0;
    logic       write3, busy3, done3, error3;
    logic [7:0] address3, data3, err_addr3, q3;
    logic [2:0] dbg3;

    logic [7:0] mem0 [256];
    logic [7:0] mem3 [256];
    logic [7:0] p1, p2;
    logic       stuck_en;
    logic [7:0] stuck_a, stuck_b;
    logic [15:0] wlog[$];
    int         wr_total;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_fill_verify #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .last_addr(last_addr), .fill_value(fill_value),
        .q(q0), .write(write0), .address(address0), .data(data0),
        .busy(busy0), .done(done0), .error(error0), .err_addr(err_addr0),
        .dbg_state(dbg0));

    mem_fill_verify #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .last_addr(last_addr), .fill_value(fill_value),
        .q(q3), .write(write3), .address(address3), .data(data3),
        .busy(busy3), .done(done3), .error(error3), .err_addr(err_addr3),
        .dbg_state(dbg3));

    function automatic logic is_stuck(input logic [7:0] a);
        return stuck_en && (a == stuck_a || a == stuck_b);
    endfunction

    // RAM models: stuck addresses always read 00
    always @(posedge clk) begin
        if (write0) begin
            mem0[address0] <= data0;
            wlog.push_back({address0, data0});
            wr_total = wr_total + 1;
        end
        q0 <= is_stuck(address0) ? 8'h00 : mem0[address0];
        if (write3) mem3[address3] <= data3;
        p1 <= is_stuck(address3) ? 8'h00 : mem3[address3];
        p2 <= p1;
        q3 <= p2;
    end

    task automatic fill_mems(input logic [7:0] v);
        for (int i = 0; i < 256; i++) begin
            mem0[i] = v;
            mem3[i] = v;
        end
    endtask

    // Waits for both instances to reach done; k counts negedges after edge E
    task automatic wait_done(input int k0, output int d0, output int d3);
        d0 = -1;
        d3 = -1;
        for (int k = k0; k < 3000; k++) begin
            @(negedge clk);
            if (d0 < 0 && done0) d0 = k + 1;
            if (d3 < 0 && done3) d3 = k + 1;
            if (d0 >= 0 && d3 >= 0) break;
        end
        checks++;
        if (d0 < 0 || d3 < 0) begin
            errors++;
            $display("FAIL done_timeout: d0=%0d d3=%0d required both done", d0, d3);
        end
    endtask

    task automatic do_run(input logic [1:0] m, input logic [7:0] b, input logic [7:0] l,
                          input logic [7:0] f, output int d0, output int d3);
        @(negedge clk);
        mode = m; base_addr = b; last_addr = l; fill_value = f;
        start = 1'b1;
        wr_total = 0;
        wlog.delete();
        @(posedge clk);
        wait_done(0, d0, d3);
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 2'b00;
        base_addr = 8'h00; last_addr = 8'h00; fill_value = 8'h00;
        stuck_en = 1'b0; stuck_a = 8'h00; stuck_b = 8'h00;
        wr_total = 0;
        repeat (3) @(negedge clk);
        checks++; if (write0 !== 1'b0)   begin errors++; $display("FAIL rst_write: got %0b want 0", write0); end
        checks++; if (address0 !== 8'h00) begin errors++; $display("FAIL rst_address: got %h want 00", address0); end
        checks++; if (data0 !== 8'h00)   begin errors++; $display("FAIL rst_data: got %h want 00", data0); end
        checks++; if (busy0 !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %0b want 0", busy0); end
        checks++; if (done0 !== 1'b0)    begin errors++; $display("FAIL rst_done: got %0b want 0", done0); end
        checks++; if (error0 !== 1'b0)   begin errors++; $display("FAIL rst_error: got %0b want 0", error0); end
        checks++; if (err_addr0 !== 8'h00) begin errors++; $display("FAIL rst_err_addr: got %h want 00", err_addr0); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // T1: full 256-word ramp
    task automatic test_ramp_full();
        int d0, d3, bad;
        fill_mems(8'h33);
        do_run(2'b00, 8'h00, 8'hFF, 8'h00, d0, d3);
        checks++; if (d0 != 257) begin errors++; $display("FAIL t1_done_edge: got %0d want 257", d0); end
        checks++; if (wr_total != 256) begin errors++; $display("FAIL t1_writes: got %0d want 256", wr_total); end
        checks++; if (error0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL t1_flags: error=%0b busy=%0b want 0 0", error0, busy0); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem0[i] !== 8'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL t1_mem: %0d words wrong, want 0", bad); end
        drop_start();
    endtask

    // T2: constant A5 over 10..1F, neighbours untouched
    task automatic test_const();
        int d0, d3, bad;
        fill_mems(8'h33);
        do_run(2'b01, 8'h10, 8'h1F, 8'hA5, d0, d3);
        checks++; if (wr_total != 16) begin errors++; $display("FAIL t2_writes: got %0d want 16", wr_total); end
        checks++; if (d0 != 17) begin errors++; $display("FAIL t2_done_edge: got %0d want 17", d0); end
        bad = 0;
        for (int i = 16'h10; i <= 16'h1F; i++) if (mem0[i] !== 8'hA5) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL t2_mem: %0d words wrong, want 0", bad); end
        checks++; if (mem0[8'h0F] !== 8'h33 || mem0[8'h20] !== 8'h33) begin
            errors++; $display("FAIL t2_untouched: mem[0F]=%h mem[20]=%h want 33 33", mem0[8'h0F], mem0[8'h20]);
        end
        drop_start();
    endtask

    // T3: wrapping range FE..01
    task automatic test_wrap();
        int d0, d3;
        logic [15:0] exp_log [4];
        exp_log[0] = 16'hFEFE; exp_log[1] = 16'hFFFF; exp_log[2] = 16'h0000; exp_log[3] = 16'h0101;
        fill_mems(8'h33);
        do_run(2'b00, 8'hFE, 8'h01, 8'h00, d0, d3);
        checks++; if (wlog.size() != 4) begin errors++; $display("FAIL t3_write_count: got %0d want 4", wlog.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                checks++;
                if (wlog[i] !== exp_log[i]) begin errors++; $display("FAIL t3_write%0d: got %h want %h", i, wlog[i], exp_log[i]); end
            end
        end
        checks++; if (d0 != 5) begin errors++; $display("FAIL t3_done_edge: got %0d want 5", d0); end
        drop_start();
    endtask

    // T4: verify with stuck words at 40 and 90; first one must be kept
    task automatic test_verify_error();
        int d0, d3;
        fill_mems(8'h33);
        stuck_en = 1'b1; stuck_a = 8'h40; stuck_b = 8'h90;
        do_run(2'b10, 8'h00, 8'hFF, 8'h00, d0, d3);
        checks++; if (d0 != 514) begin errors++; $display("FAIL t4_done_edge_lat1: got %0d want 514", d0); end
        checks++; if (d3 != 516) begin errors++; $display("FAIL t4_done_edge_lat3: got %0d want 516", d3); end
        checks++; if (error0 !== 1'b1 || err_addr0 !== 8'h40) begin errors++; $display("FAIL t4_err_lat1: error=%0b addr=%h want 1 40", error0, err_addr0); end
        checks++; if (error3 !== 1'b1 || err_addr3 !== 8'h40) begin errors++; $display("FAIL t4_err_lat3: error=%0b addr=%h want 1 40", error3, err_addr3); end
        checks++; if (wr_total != 256) begin errors++; $display("FAIL t4_writes: got %0d want 256", wr_total); end
        stuck_en = 1'b0;
    endtask

    // T6: start held after done, then drop and retrigger (follows T4, error is set)
    task automatic test_hold_retrigger();
        int d0, d3;
        wr_total = 0;
        repeat (10) @(negedge clk);
        checks++; if (wr_total != 0) begin errors++; $display("FAIL t6_no_rewrite: got %0d writes want 0", wr_total); end
        checks++; if (done0 !== 1'b1 || error0 !== 1'b1) begin errors++; $display("FAIL t6_hold: done=%0b error=%0b want 1 1", done0, error0); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL t6_done_drop: got %0b want 0", done0); end
        mode = 2'b00; base_addr = 8'h05; last_addr = 8'h07; fill_value = 8'h00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (error0 !== 1'b0 || err_addr0 !== 8'h00) begin errors++; $display("FAIL t6_err_clear: error=%0b addr=%h want 0 00", error0, err_addr0); end
        checks++; if (write0 !== 1'b1 || address0 !== 8'h05 || busy0 !== 1'b1) begin
            errors++; $display("FAIL t6_first_write: write=%0b addr=%h busy=%0b want 1 05 1", write0, address0, busy0);
        end
        wait_done(1, d0, d3);
        checks++; if (d0 != 4) begin errors++; $display("FAIL t6_done_edge: got %0d want 4", d0); end
        drop_start();
    endtask

    // Clean verify run with constant pattern
    task automatic test_verify_clean();
        int d0, d3, bad;
        fill_mems(8'h33);
        do_run(2'b11, 8'h20, 8'h2F, 8'h3C, d0, d3);
        checks++; if (d0 != 34) begin errors++; $display("FAIL tv_done_edge_lat1: got %0d want 34", d0); end
        checks++; if (d3 != 36) begin errors++; $display("FAIL tv_done_edge_lat3: got %0d want 36", d3); end
        checks++; if (error0 !== 1'b0 || error3 !== 1'b0) begin errors++; $display("FAIL tv_no_error: e0=%0b e3=%0b want 0 0", error0, error3); end
        bad = 0;
        for (int i = 16'h20; i <= 16'h2F; i++) if (mem3[i] !== 8'h3C) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL tv_mem_lat3: %0d words wrong, want 0", bad); end
        drop_start();
    endtask

    // T5: reset on the 100th write aborts at once; restart fills from base
    task automatic test_reset_mid();
        int nwr, d0, d3, bad;
        fill_mems(8'h33);
        @(negedge clk);
        mode = 2'b00; base_addr = 8'h00; last_addr = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        nwr = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (write0) nwr++;
            if (nwr == 100) break;
        end
        checks++; if (nwr != 100 || address0 !== 8'h63) begin errors++; $display("FAIL t5_100th: n=%0d addr=%h want 100 63", nwr, address0); end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (write0 !== 1'b0 || address0 !== 8'h00 || data0 !== 8'h00) begin
            errors++; $display("FAIL t5_abort: write=%0b addr=%h data=%h want 0 00 00", write0, address0, data0);
        end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || error0 !== 1'b0) begin
            errors++; $display("FAIL t5_abort_flags: busy=%0b done=%0b error=%0b want 0 0 0", busy0, done0, error0);
        end
        reset = 1'b0;
        fill_mems(8'h33);
        do_run(2'b00, 8'h00, 8'hFF, 8'h00, d0, d3);
        checks++; if (d0 != 257 || wr_total != 256) begin errors++; $display("FAIL t5_restart: done_edge=%0d writes=%0d want 257 256", d0, wr_total); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem0[i] !== 8'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL t5_mem: %0d words wrong, want 0", bad); end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_ramp_full();
        test_const();
        test_wrap();
        test_verify_error();
        test_hold_retrigger();
        test_verify_clean();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
